// File: rtl/redmule_tile_axi_mem_rsp.sv
// AXI4 responder serving one burst at a time from a single-port word-addressed SRAM.
// Define REDMULE_TILE_AXI_RSP_ERR_EN to answer out-of-window beats with SLVERR.
`timescale 1ns / 1ps

module redmule_tile_axi_mem_rsp #(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ID_W      = 4,
  parameter logic [ADDR_W-1:0] MEM_BASE  = 32'h0000_0000,
  parameter int unsigned       MEM_WORDS = 16384,
  localparam int unsigned      MEM_AW    = $clog2(MEM_WORDS)
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic [ID_W-1:0]     aw_id_i,
  input  logic [ADDR_W-1:0]   aw_addr_i,
  input  logic [7:0]          aw_len_i,
  input  logic [2:0]          aw_size_i,
  input  logic [1:0]          aw_burst_i,
  input  logic                aw_valid_i,
  output logic                aw_ready_o,
  input  logic [DATA_W-1:0]   w_data_i,
  input  logic [DATA_W/8-1:0] w_strb_i,
  input  logic                w_last_i,
  input  logic                w_valid_i,
  output logic                w_ready_o,
  output logic [ID_W-1:0]     b_id_o,
  output logic [1:0]          b_resp_o,
  output logic                b_valid_o,
  input  logic                b_ready_i,
  input  logic [ID_W-1:0]     ar_id_i,
  input  logic [ADDR_W-1:0]   ar_addr_i,
  input  logic [7:0]          ar_len_i,
  input  logic [2:0]          ar_size_i,
  input  logic [1:0]          ar_burst_i,
  input  logic                ar_valid_i,
  output logic                ar_ready_o,
  output logic [ID_W-1:0]     r_id_o,
  output logic [DATA_W-1:0]   r_data_o,
  output logic [1:0]          r_resp_o,
  output logic                r_last_o,
  output logic                r_valid_o,
  input  logic                r_ready_i,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [MEM_AW-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

`ifdef REDMULE_TILE_AXI_RSP_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  localparam logic [1:0]        RespOkay   = 2'b00;
  localparam logic [1:0]        RespSlvErr = 2'b10;
  localparam logic [ADDR_W+1:0] MemBytes   = (ADDR_W + 2)'(MEM_WORDS) << 2;

  typedef enum logic [2:0] {StIdle, StWrData, StWrResp, StRdReq, StRdWait} state_e;

  state_e              state_q;
  logic [ID_W-1:0]     id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          len_q, beat_q;
  logic [2:0]          size_q;
  logic [1:0]          burst_q;
  logic                last_wr_q, wr_err_q, rd_first_q;
  logic [1:0]          r_resp_q;
  logic [DATA_W-1:0]   r_data_q;

  logic                sel_wr, aw_hs, ar_hs, w_hs, rd_req, addr_ok, in_range, last_beat;
  logic [ADDR_W:0]     offset;
  logic [ADDR_W-1:0]   step, next_addr;

  // Alternating priority: on contention the channel not served last wins.
  assign sel_wr     = aw_valid_i & (~ar_valid_i | ~last_wr_q);
  assign aw_ready_o = (state_q == StIdle) & sel_wr;
  assign ar_ready_o = (state_q == StIdle) & ar_valid_i & ~sel_wr;
  assign aw_hs      = aw_valid_i & aw_ready_o;
  assign ar_hs      = ar_valid_i & ar_ready_o;
  assign w_ready_o  = (state_q == StWrData);
  assign w_hs       = w_valid_i & w_ready_o;
  assign rd_req     = (state_q == StRdReq);

  // Top bit of the offset is the borrow: set when the address lies below the window.
  assign offset    = {1'b0, addr_q} - {1'b0, MEM_BASE};
  assign addr_ok   = ~offset[ADDR_W] & ({1'b0, offset} < MemBytes);
  assign in_range  = ~ErrEn | addr_ok;

  assign step      = ADDR_W'(1) << ((size_q > 3'd2) ? 3'd2 : size_q);
  assign next_addr = (burst_q == 2'b00) ? addr_q : addr_q + step;
  assign last_beat = (beat_q == len_q);

  assign mem_req_o   = (w_hs | rd_req) & in_range;
  assign mem_we_o    = w_hs & in_range;
  assign mem_addr_o  = mem_req_o ? offset[MEM_AW+1:2] : '0;
  assign mem_wdata_o = mem_we_o ? w_data_i : '0;
  assign mem_be_o    = mem_we_o ? w_strb_i : '0;

  assign b_valid_o = (state_q == StWrResp);
  assign b_id_o    = id_q;
  assign b_resp_o  = wr_err_q ? RespSlvErr : RespOkay;

  // SRAM data arrives in the first RD_WAIT cycle; it is held in r_data_q from then on.
  assign r_valid_o = (state_q == StRdWait);
  assign r_last_o  = r_valid_o & last_beat;
  assign r_id_o    = id_q;
  assign r_resp_o  = r_resp_q;
  assign r_data_o  = rd_first_q ? ((r_resp_q == RespOkay) ? mem_rdata_i : '0) : r_data_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= StIdle;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      beat_q     <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      last_wr_q  <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_first_q <= 1'b0;
      r_resp_q   <= RespOkay;
      r_data_q   <= '0;
    end else begin
      rd_first_q <= 1'b0;
      if (rd_first_q) r_data_q <= r_data_o;
      unique case (state_q)
        StIdle: begin
          if (aw_hs) begin
            state_q   <= StWrData;
            id_q      <= aw_id_i;
            addr_q    <= aw_addr_i;
            len_q     <= aw_len_i;
            size_q    <= aw_size_i;
            burst_q   <= aw_burst_i;
            beat_q    <= '0;
            wr_err_q  <= 1'b0;
            last_wr_q <= 1'b1;
          end else if (ar_hs) begin
            state_q   <= StRdReq;
            id_q      <= ar_id_i;
            addr_q    <= ar_addr_i;
            len_q     <= ar_len_i;
            size_q    <= ar_size_i;
            burst_q   <= ar_burst_i;
            beat_q    <= '0;
            last_wr_q <= 1'b0;
          end
        end
        StWrData: begin
          if (w_hs) begin
            addr_q <= next_addr;
            beat_q <= beat_q + 8'd1;
            if (!in_range) wr_err_q <= 1'b1;
            if (w_last_i) state_q <= StWrResp;
          end
        end
        StWrResp: begin
          if (b_ready_i) state_q <= StIdle;
        end
        StRdReq: begin
          state_q    <= StRdWait;
          rd_first_q <= 1'b1;
          r_resp_q   <= in_range ? RespOkay : RespSlvErr;
        end
        StRdWait: begin
          if (r_ready_i) begin
            if (last_beat) begin
              state_q <= StIdle;
            end else begin
              addr_q  <= next_addr;
              beat_q  <= beat_q + 8'd1;
              state_q <= StRdReq;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_redmule_tile_axi_mem_rsp.sv
// Directed plus randomized bench for redmule_tile_axi_mem_rsp with a behavioural SRAM model.
`timescale 1ns / 1ps

module tb_redmule_tile_axi_mem_rsp;
  localparam int unsigned MW   = 16384;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk_i = 1'b0, rstn_i = 1'b0;
  logic [3:0]  aw_id_i = '0, ar_id_i = '0;
  logic [31:0] aw_addr_i = '0, ar_addr_i = '0;
  logic [7:0]  aw_len_i = '0, ar_len_i = '0;
  logic [2:0]  aw_size_i = '0, ar_size_i = '0;
  logic [1:0]  aw_burst_i = '0, ar_burst_i = '0;
  logic        aw_valid_i = 1'b0, ar_valid_i = 1'b0, aw_ready_o, ar_ready_o;
  logic [31:0] w_data_i = '0;
  logic [3:0]  w_strb_i = '0;
  logic        w_last_i = 1'b0, w_valid_i = 1'b0, w_ready_o;
  logic [3:0]  b_id_o, r_id_o;
  logic [1:0]  b_resp_o, r_resp_o;
  logic        b_valid_o, b_ready_i = 1'b0;
  logic [31:0] r_data_o;
  logic        r_last_o, r_valid_o, r_ready_i = 1'b0;
  logic        mem_req_o, mem_we_o;
  logic [13:0] mem_addr_o;
  logic [31:0] mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_be_o;

  always #5 clk_i = ~clk_i;

  redmule_tile_axi_mem_rsp #(
    .ADDR_W(32), .DATA_W(32), .ID_W(4), .MEM_BASE(BASE), .MEM_WORDS(MW)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i), .aw_size_i(aw_size_i),
    .aw_burst_i(aw_burst_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
    .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_last_i(w_last_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
    .b_id_o(b_id_o), .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
    .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i), .ar_size_i(ar_size_i),
    .ar_burst_i(ar_burst_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
    .r_id_o(r_id_o), .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i)
  );

  // SRAM: byte-enabled write, registered read data.
  logic [31:0] sram [MW];
  logic        mem_clr = 1'b1;
  always @(posedge clk_i) begin
    if (mem_clr) begin
      for (int k = 0; k < MW; k++) sram[k] <= '0;
    end else if (mem_req_o && mem_we_o) begin
      for (int b = 0; b < 4; b++) if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
    end else if (mem_req_o) begin
      mem_rdata_i <= sram[mem_addr_o];
    end
  end

  logic [31:0] ref_mem [MW];
  logic [31:0] wdat [256];
  logic [3:0]  wstb [256];
  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
`ifdef REDMULE_TILE_AXI_RSP_ERR_EN
    longint off = longint'(a) - longint'(BASE);
    return (off >= 0) && (off < longint'(4 * MW));
`else
    return (a === a);
`endif
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    return int'((a - BASE) >> 2) % MW;
  endfunction

  function automatic logic [31:0] adv(input logic [31:0] a, input logic [1:0] burst,
                                      input logic [2:0] size);
    int unsigned sz = (size > 3'd2) ? 2 : int'(size);
    if (burst == 2'b00) return a;
    return a + (32'd1 << sz);
  endfunction

  task automatic wait_ready(input string tag, input bit is_aw);
    int n = 0;
    while ((is_aw ? aw_ready_o : ar_ready_o) !== 1'b1 && n < 20) begin
      @(posedge clk_i); #2; n++;
    end
    chk(tag, is_aw ? aw_ready_o : ar_ready_o, 1);
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [1:0] burst, input logic [2:0] size, input bit gaps);
    logic [31:0] a = addr;
    bit err = 0;
    aw_id_i = id; aw_addr_i = addr; aw_len_i = len; aw_burst_i = burst; aw_size_i = size;
    aw_valid_i = 1'b1; #1;
    wait_ready("aw_ready", 1);
    @(posedge clk_i); #1; aw_valid_i = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        w_valid_i = 1'b0; #1;
        chk("w_gap_noreq", mem_req_o, 0);
        @(posedge clk_i); #1;
      end
      w_valid_i = 1'b1; w_data_i = wdat[i]; w_strb_i = wstb[i]; w_last_i = (i == int'(len)); #1;
      chk("w_ready", w_ready_o, 1);
      if (in_rng(a)) begin
        chk("w_req", {mem_req_o, mem_we_o}, 2'b11);
        chk("w_addr", mem_addr_o, widx(a));
        chk("w_be", mem_be_o, wstb[i]);
        chk("w_data", mem_wdata_o, wdat[i]);
        for (int b = 0; b < 4; b++) if (wstb[i][b]) ref_mem[widx(a)][8*b +: 8] = wdat[i][8*b +: 8];
      end else begin
        chk("w_oor_noreq", mem_req_o, 0);
        err = 1;
      end
      @(posedge clk_i); #1;
      a = adv(a, burst, size);
    end
    w_valid_i = 1'b0; w_last_i = 1'b0; #1;
    chk("b_valid", b_valid_o, 1);
    chk("b_id", b_id_o, id);
    chk("b_resp", b_resp_o, err ? 2 : 0);
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk_i); #2;
      chk("b_hold", {b_valid_o, b_id_o, b_resp_o}, {1'b1, id, (err ? 2'b10 : 2'b00)});
    end
    b_ready_i = 1'b1;
    @(posedge clk_i); #1; b_ready_i = 1'b0; #1;
    chk("b_done", b_valid_o, 0);
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input bit stalls,
                            input int stall_beat, input int stall_n);
    logic [31:0] a = addr;
    logic [31:0] expd;
    logic [1:0]  expr;
    bit e, last;
    int ns;
    ar_id_i = id; ar_addr_i = addr; ar_len_i = len; ar_burst_i = burst; ar_size_i = size;
    ar_valid_i = 1'b1; #1;
    wait_ready("ar_ready", 0);
    @(posedge clk_i); #1; ar_valid_i = 1'b0; #1;
    for (int i = 0; i <= int'(len); i++) begin
      e = in_rng(a);
      last = (i == int'(len));
      chk("rd_req", {mem_req_o, mem_we_o}, {e, 1'b0});
      if (e) chk("rd_addr", mem_addr_o, widx(a));
      chk("rd_nvalid", r_valid_o, 0);
      @(posedge clk_i); #2;
      expd = e ? ref_mem[widx(a)] : 32'h0;
      expr = e ? 2'b00 : 2'b10;
      chk("r_valid", r_valid_o, 1);
      chk("r_data", r_data_o, expd);
      chk("r_last", r_last_o, last);
      chk("r_id", r_id_o, id);
      chk("r_resp", r_resp_o, expr);
      ns = (i == stall_beat) ? stall_n : (stalls ? int'($urandom_range(0, 3)) : 0);
      repeat (ns) begin
        @(posedge clk_i); #2;
        chk("r_hold", {r_valid_o, r_last_o, r_id_o, r_resp_o, r_data_o}, {1'b1, last, id, expr, expd});
        chk("r_stall_noreq", mem_req_o, 0);
      end
      r_ready_i = 1'b1;
      @(posedge clk_i); #1; r_ready_i = 1'b0; #1;
      a = adv(a, burst, size);
    end
    chk("r_done", r_valid_o, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [2:0]  size;
    for (int k = 0; k < MW; k++) ref_mem[k] = '0;
    repeat (2) @(posedge clk_i);
    #1; mem_clr = 1'b0;
    chk("rst_ctrl", {aw_ready_o, ar_ready_o, w_ready_o, b_valid_o, r_valid_o, r_last_o,
                     mem_req_o, mem_we_o}, 0);
    chk("rst_data", {r_data_o, b_resp_o, r_resp_o, b_id_o, r_id_o}, 0);
    chk("rst_mem", {mem_addr_o, mem_wdata_o, mem_be_o}, 0);
    @(posedge clk_i); #1; rstn_i = 1'b1;
    @(posedge clk_i); #2;

    // Plain INCR write then read-back of the same four words.
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'hA0 + i; wstb[i] = 4'hF; end
    write_burst(4'h5, BASE + 32'h10, 8'd3, 2'b01, 3'd2, 1'b0);
    for (int i = 0; i < 4; i++) chk("plan_sram", sram[4+i], 32'hA0 + i);
    read_burst(4'h6, BASE + 32'h10, 8'd3, 2'b01, 3'd2, 1'b0, -1, 0);

    // Contention: write, then read, then write.
    ar_valid_i = 1'b1; aw_valid_i = 1'b1; #1;
    chk("arb1", {aw_ready_o, ar_ready_o}, 2'b10);
    wdat[0] = 32'h1111_0001; wstb[0] = 4'hF;
    write_burst(4'h1, BASE + 32'h40, 8'd0, 2'b01, 3'd2, 1'b0);
    aw_valid_i = 1'b1; #1;
    chk("arb2", {aw_ready_o, ar_ready_o}, 2'b01);
    read_burst(4'h2, BASE + 32'h40, 8'd0, 2'b01, 3'd2, 1'b0, -1, 0);
    ar_valid_i = 1'b1; #1;
    chk("arb3", {aw_ready_o, ar_ready_o}, 2'b10);
    wdat[0] = 32'h2222_0002; wstb[0] = 4'hF;
    write_burst(4'h3, BASE + 32'h44, 8'd0, 2'b01, 3'd2, 1'b0);
    read_burst(4'h4, BASE + 32'h40, 8'd1, 2'b01, 3'd2, 1'b0, -1, 0);

    // R backpressure for five cycles on beat 1.
    read_burst(4'h7, BASE + 32'h10, 8'd3, 2'b01, 3'd2, 1'b0, 1, 5);

    // FIXED burst merges three single-byte strobes into word 8.
    for (int i = 0; i < 3; i++) begin wdat[i] = $urandom; wstb[i] = 4'b0001 << i; end
    write_burst(4'h8, BASE + 32'h20, 8'd2, 2'b00, 3'd2, 1'b0);
    chk("fixed_merge", sram[8], {8'h00, wdat[2][23:16], wdat[1][15:8], wdat[0][7:0]});
    read_burst(4'h8, BASE + 32'h20, 8'd0, 2'b01, 3'd2, 1'b0, -1, 0);

`ifdef REDMULE_TILE_AXI_RSP_ERR_EN
    read_burst(4'h9, BASE + 4 * MW, 8'd0, 2'b01, 3'd2, 1'b0, -1, 0);
    for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
    write_burst(4'hA, BASE + 4 * MW - 8, 8'd3, 2'b01, 3'd2, 1'b0);
    read_burst(4'hA, BASE + 4 * MW - 8, 8'd3, 2'b01, 3'd2, 1'b0, -1, 0);
`else
    read_burst(4'h9, BASE + 4 * MW + 32'h10, 8'd1, 2'b01, 3'd2, 1'b0, -1, 0);
    for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
    write_burst(4'hA, BASE + 4 * MW - 8, 8'd3, 2'b01, 3'd2, 1'b0);
    read_burst(4'hA, BASE + 4 * MW - 8, 8'd3, 2'b01, 3'd2, 1'b0, -1, 0);
`endif

    // Randomized bursts: any size, burst type, alignment, strobes, gaps and stalls.
    for (int t = 0; t < 25; t++) begin
      id    = 4'($urandom);
      addr  = BASE + $urandom_range(0, 4 * MW - 1);
      len   = 8'($urandom_range(0, 7));
      burst = 2'($urandom_range(0, 2));
      size  = 3'($urandom_range(0, 3));
      for (int i = 0; i <= int'(len); i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom); end
      write_burst(id, addr, len, burst, size, 1'b1);
      read_burst(~id, addr, len, burst, size, 1'b1, -1, 0);
    end

    // Reset in the middle of a read burst.
    ar_id_i = 4'hC; ar_addr_i = BASE + 32'h10; ar_len_i = 8'd3; ar_burst_i = 2'b01;
    ar_size_i = 3'd2; ar_valid_i = 1'b1; #1;
    wait_ready("mid_ar_ready", 0);
    @(posedge clk_i); #1; ar_valid_i = 1'b0;
    @(posedge clk_i); #2;
    chk("mid_rvalid", r_valid_o, 1);
    rstn_i = 1'b0; #1;
    chk("mid_rst_ctrl", {r_valid_o, b_valid_o, w_ready_o, mem_req_o, r_last_o, aw_ready_o,
                         ar_ready_o}, 0);
    chk("mid_rst_data", r_data_o, 0);
    @(posedge clk_i); #1; rstn_i = 1'b1; #1;
    ar_valid_i = 1'b1; ar_id_i = 4'hD; #1;
    chk("post_rst_idle", ar_ready_o, 1);
    read_burst(4'hD, BASE + 32'h10, 8'd3, 2'b01, 3'd2, 1'b0, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
